// File: rtl/wf_fetch_sched_if.sv
// Fetch request/response channel between the wavefront fetch scheduler (master) and the instruction buffer (slave).
// The request path uses a valid/ready handshake. The response is a single-cycle ack tagged with the wavefront id.
interface wf_fetch_sched_if #(
  parameter int WFID_W = 6,
  parameter int PC_W   = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic [PC_W-1:0]   req_addr;
  logic [WFID_W-1:0] req_wfid;
  logic              resp_ack;
  logic [WFID_W-1:0] resp_wfid;

  modport master (
    output req_valid, req_addr, req_wfid,
    input  req_ready, resp_ack, resp_wfid
  );

  modport slave (
    input  req_valid, req_addr, req_wfid,
    output req_ready, resp_ack, resp_wfid
  );
endinterface

// File: rtl/wf_fetch_sched.sv
// Round-robin per-wavefront fetch scheduler: a PC table plus active/pending masks. The request is registered, so it comes 1 cycle after eligibility.
// The presented request holds under req_ready=0 and is withdrawn if its slot is retired, redirected or stopped. Total in-flight fetches are capped at MAX_OUTSTANDING.
module wf_fetch_sched #(
  parameter int NUM_WF          = 40,
  parameter int WFID_W          = 6,
  parameter int PC_W            = 32,
  parameter int FETCH_BYTES     = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wf_alloc_en,
  input  logic [WFID_W-1:0] wf_alloc_id,
  input  logic [PC_W-1:0]   wf_alloc_pc,
  input  logic              wf_done_en,
  input  logic [WFID_W-1:0] wf_done_id,
  input  logic              branch_en,
  input  logic [WFID_W-1:0] branch_wfid,
  input  logic [PC_W-1:0]   branch_pc,
  input  logic [NUM_WF-1:0] stop_fetch,
  wf_fetch_sched_if.master  fetch,
  output logic [NUM_WF-1:0] active,
  output logic [CNT_W-1:0]  outstanding
);

  localparam logic [WFID_W:0]   NUM_WF_X = (WFID_W+1)'(NUM_WF);
  localparam logic [NUM_WF-1:0] SLOT0    = NUM_WF'(1);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PC_W-1:0]   PC_STEP  = PC_W'(FETCH_BYTES);
  localparam logic [WFID_W-1:0] LAST_ID  = WFID_W'(NUM_WF - 1);
  localparam logic [WFID_W-1:0] ID_ONE   = WFID_W'(1);

  // One-hot slot decode; out-of-range ids decode to nothing and are thereby ignored.
  function automatic logic [NUM_WF-1:0] slot_vec(input logic en, input logic [WFID_W-1:0] id);
    slot_vec = '0;
    if (en && ({1'b0, id} < NUM_WF_X)) slot_vec = SLOT0 << id;
  endfunction

  logic [NUM_WF-1:0] active_q, active_d;
  logic [NUM_WF-1:0] pending_q, pending_d;
  logic [PC_W-1:0]   pc_q [NUM_WF];
  logic [PC_W-1:0]   pc_d [NUM_WF];
  logic [WFID_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic              req_valid_q;
  logic [PC_W-1:0]   req_addr_q;
  logic [WFID_W-1:0] req_wfid_q;

  logic [NUM_WF-1:0] alloc_vec, done_vec, branch_vec, resp_vec, hs_vec, cur_vec, elig;
  logic              hs, withdraw, sel_found, can_sel;
  logic [WFID_W-1:0] sel_id;
  logic [WFID_W:0]   idx;

  assign alloc_vec  = slot_vec(wf_alloc_en, wf_alloc_id);
  assign done_vec   = slot_vec(wf_done_en, wf_done_id) & ~alloc_vec;
  assign branch_vec = slot_vec(branch_en, branch_wfid);
  assign resp_vec   = slot_vec(fetch.resp_ack, fetch.resp_wfid) & pending_q;
  assign hs         = req_valid_q & fetch.req_ready;
  assign hs_vec     = slot_vec(hs, req_wfid_q);
  assign cur_vec    = slot_vec(req_valid_q, req_wfid_q);

  // A stalled request whose slot changes under it is dropped; its PC is not advanced.
  assign withdraw = req_valid_q & ~fetch.req_ready &
                    (|(cur_vec & (alloc_vec | done_vec | branch_vec | stop_fetch)));

  assign active_d  = (active_q | alloc_vec) & ~done_vec;
  assign pending_d = (pending_q & ~resp_vec) | hs_vec;
  assign rr_d      = hs ? ((req_wfid_q == LAST_ID) ? '0 : req_wfid_q + ID_ONE) : rr_q;

  always_comb begin
    unique case ({hs, |resp_vec})
      2'b10:   out_d = out_q + CNT_ONE;
      2'b01:   out_d = out_q - CNT_ONE;
      default: out_d = out_q;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_WF; i++) begin
      if (alloc_vec[i])       pc_d[i] = wf_alloc_pc;
      else if (branch_vec[i]) pc_d[i] = branch_pc;
      else if (hs_vec[i])     pc_d[i] = pc_q[i] + PC_STEP;
      else                    pc_d[i] = pc_q[i];
    end
  end

  // Registered active keeps alloc-to-request at one extra cycle; next-state pending excludes the slot just accepted.
  assign elig = active_q & ~done_vec & ~pending_d & ~stop_fetch;

  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = '0;
    for (int k = 0; k < NUM_WF; k++) begin
      idx = {1'b0, rr_d} + (WFID_W+1)'(k);
      if (idx >= NUM_WF_X) idx = idx - NUM_WF_X;
      if (!sel_found && elig[idx[WFID_W-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = idx[WFID_W-1:0];
      end
    end
  end

  assign can_sel = (~req_valid_q | hs) & sel_found & (out_d < MAX_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q    <= '0;
      pending_q   <= '0;
      rr_q        <= '0;
      out_q       <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_wfid_q  <= '0;
      for (int i = 0; i < NUM_WF; i++) pc_q[i] <= '0;
    end else begin
      active_q  <= active_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      out_q     <= out_d;
      pc_q      <= pc_d;
      if (can_sel) begin
        req_valid_q <= 1'b1;
        req_addr_q  <= pc_d[sel_id];
        req_wfid_q  <= sel_id;
      end else if (hs || withdraw) begin
        req_valid_q <= 1'b0;
      end
    end
  end

  assign fetch.req_valid = req_valid_q;
  assign fetch.req_addr  = req_addr_q;
  assign fetch.req_wfid  = req_wfid_q;
  assign active          = active_q;
  assign outstanding     = out_q;

endmodule
